// File: rtl/captura_hamming.sv
// captura_hamming
// Front end of the Hamming SECDED display path. It synchronises and debounces
// the load button and synchronises the switch word. Each debounced press
// starts a three-stage decode: capture, syndrome, correct. The corrected
// nibble and the error position stay on the outputs until the next decode
// completes.
//
// state    | meaning
// IDLE     | no result yet, waiting for a press
// CAPTURA  | switch word latched, syndrome/parity being registered
// SINDROME | correction being registered onto the outputs
// MUESTRA  | result held, waiting for the next press
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   btn_cargar      raw load push-button (polarity set by BTN_ACTIVO_BAJO)
//   palabra_rx      raw switch word: [6:0] Hamming positions 1..7, [7] overall parity
//   w_corregida_b4  {0,d4,d3,d2,d1}; 5'b10000 flags a double error
//   error_pos       corrected position 1..7, 8 = parity bit, 0 = none/double
//   valido          outputs hold a completed decode
//   ocupado         decode in progress
module captura_hamming #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit BTN_ACTIVO_BAJO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_cargar,
    input  logic [7:0] palabra_rx,
    output logic [4:0] w_corregida_b4,
    output logic [3:0] error_pos,
    output logic       valido,
    output logic       ocupado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURA  = 2'd1,
        SINDROME = 2'd2,
        MUESTRA  = 2'd3
    } estado_t;

    logic [1:0]    btn_sync;
    logic [7:0]    rx_sync1;
    logic [7:0]    rx_sync2;
    logic          btn_nivel;
    logic [CW-1:0] cnt_deb;
    logic          btn_deb;
    logic          btn_deb_d;
    logic          pulso_carga;

    estado_t       estado;
    estado_t       estado_sig;
    logic          cargar;

    logic [7:0]    palabra_q;
    logic [2:0]    sind_q;
    logic          par_q;

    logic [6:0]    pos_corr;
    logic [4:0]    w_sig;
    logic [3:0]    pos_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            rx_sync1 <= '0;
            rx_sync2 <= '0;
        end else begin
            btn_sync <= {btn_sync[0], btn_cargar};
            rx_sync1 <= palabra_rx;
            rx_sync2 <= rx_sync1;
        end
    end

    // Polarity is normalised after the synchroniser so that 1 always means pressed.
    assign btn_nivel = BTN_ACTIVO_BAJO ? ~btn_sync[1] : btn_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_deb   <= '0;
            btn_deb   <= 1'b0;
            btn_deb_d <= 1'b0;
        end else begin
            btn_deb_d <= btn_deb;
            if (btn_nivel == btn_deb) begin
                cnt_deb <= '0;
            end else if (cnt_deb == CNT_FIN) begin
                btn_deb <= btn_nivel;
                cnt_deb <= '0;
            end else begin
                cnt_deb <= cnt_deb + 1'b1;
            end
        end
    end

    // Only the debounced press edge loads; release is ignored.
    assign pulso_carga = btn_deb & ~btn_deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        cargar     = 1'b0;
        case (estado)
            IDLE, MUESTRA: begin
                if (pulso_carga) begin
                    estado_sig = CAPTURA;
                    cargar     = 1'b1;
                end
            end
            CAPTURA:  estado_sig = SINDROME;
            SINDROME: estado_sig = MUESTRA;
            default:  estado_sig = IDLE;
        endcase
    end

    assign ocupado = (estado == CAPTURA) || (estado == SINDROME);

    // Correction from the registered syndrome and parity.
    always_comb begin
        pos_corr = palabra_q[6:0];
        for (int i = 0; i < 7; i++) begin
            if (sind_q == 3'(i + 1)) begin
                pos_corr[i] = ~palabra_q[i];
            end
        end

        w_sig   = {1'b0, palabra_q[6], palabra_q[5], palabra_q[4], palabra_q[2]};
        pos_sig = 4'd0;
        if (sind_q != 3'd0 && par_q) begin
            w_sig   = {1'b0, pos_corr[6], pos_corr[5], pos_corr[4], pos_corr[2]};
            pos_sig = {1'b0, sind_q};
        end else if (sind_q == 3'd0 && par_q) begin
            pos_sig = 4'd8;
        end else if (sind_q != 3'd0 && !par_q) begin
            w_sig   = 5'b10000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            palabra_q      <= '0;
            sind_q         <= '0;
            par_q          <= 1'b0;
            w_corregida_b4 <= '0;
            error_pos      <= '0;
            valido         <= 1'b0;
        end else begin
            if (cargar) begin
                palabra_q <= rx_sync2;
                valido    <= 1'b0;
            end
            if (estado == CAPTURA) begin
                sind_q <= {palabra_q[3] ^ palabra_q[4] ^ palabra_q[5] ^ palabra_q[6],
                           palabra_q[1] ^ palabra_q[2] ^ palabra_q[5] ^ palabra_q[6],
                           palabra_q[0] ^ palabra_q[2] ^ palabra_q[4] ^ palabra_q[6]};
                par_q  <= ^palabra_q;
            end
            if (estado == SINDROME) begin
                w_corregida_b4 <= w_sig;
                error_pos      <= pos_sig;
                valido         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_captura_hamming.sv
// Testbench for captura_hamming: directed SECDED words, random words checked
// against a behavioural decoder, button bounce, holding behaviour and reset
// in the middle of a decode.
module tb_captura_hamming;

    logic       clk;
    logic       rst_n;
    logic       btn_cargar;
    logic [7:0] palabra_rx;
    logic [4:0] w_corregida_b4;
    logic [3:0] error_pos;
    logic       valido;
    logic       ocupado;

    int total = 0;
    int bad   = 0;

    captura_hamming #(
        .DEBOUNCE_CYCLES(8),
        .BTN_ACTIVO_BAJO(1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_cargar     (btn_cargar),
        .palabra_rx     (palabra_rx),
        .w_corregida_b4 (w_corregida_b4),
        .error_pos      (error_pos),
        .valido         (valido),
        .ocupado        (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Reference decoder: the syndrome is the XOR of the indices of all set
    // positions; the overall parity covers all eight bits.
    function automatic logic [8:0] modelo(input logic [7:0] w);
        int          s;
        int          unos;
        logic [7:0]  c;
        logic [4:0]  dat;
        logic [3:0]  pos;
        s    = 0;
        unos = 0;
        c    = w;
        for (int i = 1; i <= 7; i++) if (w[i-1]) s = s ^ i;
        for (int i = 0; i < 8; i++) if (w[i]) unos++;
        pos = 4'd0;
        if (s != 0 && (unos % 2) == 1) begin
            c[s-1] = ~c[s-1];
            pos    = 4'(s);
        end else if (s == 0 && (unos % 2) == 1) begin
            pos = 4'd8;
        end
        if (s != 0 && (unos % 2) == 0) dat = 5'b10000;
        else                           dat = {1'b0, c[6], c[5], c[4], c[2]};
        return {dat, pos};
    endfunction

    task automatic esperar_ocupado(input string tag);
        int n;
        n = 0;
        while (!ocupado && n < 60) begin
            @(negedge clk);
            n++;
        end
        chequear({tag, " arranque"}, 32'(ocupado), 32'd1);
    endtask

    task automatic pulsar_y_verificar(input logic [7:0] w, input string tag);
        logic [8:0] esp;
        int         c;
        esp = modelo(w);
        palabra_rx = w;
        repeat (3) @(negedge clk);
        btn_cargar = 1'b0;
        esperar_ocupado(tag);
        chequear({tag, " valido en curso"}, 32'(valido), 32'd0);
        // The word is already latched; later switch changes must not matter.
        palabra_rx = 8'($urandom);
        c = 0;
        while (ocupado && c < 10) begin
            @(negedge clk);
            c++;
        end
        chequear({tag, " ciclos ocupado"}, 32'(c), 32'd2);
        chequear({tag, " valido"}, 32'(valido), 32'd1);
        chequear({tag, " dato"}, 32'(w_corregida_b4), 32'(esp[8:4]));
        chequear({tag, " pos"}, 32'(error_pos), 32'(esp[3:0]));
        btn_cargar = 1'b1;
        palabra_rx = 8'($urandom);
        repeat (20) @(negedge clk);
        chequear({tag, " retenido dato"}, 32'(w_corregida_b4), 32'(esp[8:4]));
        chequear({tag, " retenido pos"}, 32'(error_pos), 32'(esp[3:0]));
    endtask

    initial begin
        logic [4:0] w_prev;
        logic [3:0] p_prev;
        logic       visto;

        rst_n      = 1'b0;
        btn_cargar = 1'b1;
        palabra_rx = 8'h00;
        repeat (3) @(negedge clk);
        chequear("reset dato", 32'(w_corregida_b4), 32'd0);
        chequear("reset pos", 32'(error_pos), 32'd0);
        chequear("reset valido", 32'(valido), 32'd0);
        chequear("reset ocupado", 32'(ocupado), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chequear("sin pulsar valido", 32'(valido), 32'd0);

        pulsar_y_verificar(8'h55, "limpia");
        pulsar_y_verificar(8'h45, "error pos5");
        pulsar_y_verificar(8'hD5, "error paridad");
        pulsar_y_verificar(8'h56, "doble error");

        // Bounce shorter than the debounce window must not start a decode.
        w_prev     = w_corregida_b4;
        p_prev     = error_pos;
        visto      = 1'b0;
        palabra_rx = 8'h45;
        for (int k = 0; k < 6; k++) begin
            btn_cargar = 1'b0;
            repeat (3) begin @(negedge clk); if (ocupado) visto = 1'b1; end
            btn_cargar = 1'b1;
            repeat (3) begin @(negedge clk); if (ocupado) visto = 1'b1; end
        end
        repeat (20) begin @(negedge clk); if (ocupado) visto = 1'b1; end
        chequear("rebote ocupado", 32'(visto), 32'd0);
        chequear("rebote dato", 32'(w_corregida_b4), 32'(w_prev));
        chequear("rebote pos", 32'(error_pos), 32'(p_prev));

        for (int k = 0; k < 20; k++) begin
            pulsar_y_verificar(8'($urandom), "aleatoria");
        end

        // Reset while in SINDROME clears everything asynchronously.
        palabra_rx = 8'h45;
        repeat (3) @(negedge clk);
        btn_cargar = 1'b0;
        esperar_ocupado("reset medio");
        @(posedge clk);
        #1;
        chequear("reset medio sindrome", 32'(ocupado), 32'd1);
        rst_n = 1'b0;
        #1;
        chequear("reset medio dato", 32'(w_corregida_b4), 32'd0);
        chequear("reset medio pos", 32'(error_pos), 32'd0);
        chequear("reset medio valido", 32'(valido), 32'd0);
        chequear("reset medio ocupado", 32'(ocupado), 32'd0);
        btn_cargar = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chequear("tras reset valido", 32'(valido), 32'd0);
        pulsar_y_verificar(8'h45, "tras reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
